soda_vend_ctrl: RTL

Parametrised, fully synchronous vending controller. Accepts nickel/dime/quarter coin pulses, accumulates credit up to a ceiling, and dispenses once credit reaches PRICE. Returns change as a paced sequence of individual dime and nickel ejects, and supports cancel/refund. Drives the board's 4-digit active-low 7-segment display with the live credit in decimal; sits between the coin-switch inputs and the dispenser/coin-return actuators.

---
 rtl/soda_vend_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/soda_vend_ctrl.sv
// soda_vend_ctrl
//   Coin-operated vending controller. Conditions the raw coin/cancel switches,
//   accumulates credit up to MAX_CREDIT, dispenses once credit reaches PRICE,
//   pays change back as paced dime/nickel ejects and drives a multiplexed
//   active-low 4-digit 7-segment display with the live credit.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   nickels/dimes/quarters/cancel  raw asynchronous switches, active high
//   dispance       one-cycle dispense pulse
//   returnnickels  one-cycle pulse per nickel ejected
//   returndimes    one-cycle pulse per dime ejected
//   coin_reject    one-cycle pulse when an inserted coin is refused
//   busy           high while vending or paying change
//   credit         current credit in cents (binary)
//   an             digit enables, active low
//   a_to_g         segments a..g (a = bit 6), active low
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting coins / cancel
// VEND   | one cycle: dispense and subtract PRICE
// CHANGE | ejecting dimes then nickels, CHANGE_GAP cycles apart
module soda_vend_ctrl #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int CHANGE_GAP = 4,
    parameter int REFRESH_W  = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nickels,
    input  logic       dimes,
    input  logic       quarters,
    input  logic       cancel,
    output logic       dispance,
    output logic       returnnickels,
    output logic       returndimes,
    output logic       coin_reject,
    output logic       busy,
    output logic [6:0] credit,
    output logic [3:0] an,
    output logic [6:0] a_to_g
);

    typedef enum logic [1:0] {ST_IDLE, ST_VEND, ST_CHANGE} state_t;

    localparam logic [6:0] PRICE_C = 7'(PRICE);
    localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);
    localparam int         GAP_W   = $clog2(CHANGE_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CHANGE_GAP - 1);

    // bit order {cancel, quarters, dimes, nickels}
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [3:0] ev;

    state_t              state_q, state_d;
    logic [6:0]          credit_q, credit_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    logic [6:0] coin_sum;
    logic [7:0] sum_total;
    logic       coin_any;
    logic [3:0] tens;
    logic [3:0] ones;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            state_q   <= ST_IDLE;
            credit_q  <= '0;
            gap_q     <= '0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            state_q   <= state_d;
            credit_q  <= credit_d;
            gap_q     <= gap_d;
            refresh_q <= refresh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    // sync3 is the previous synchronised level, used only for edge detection
    always_comb begin
        sync1_d = {cancel, quarters, dimes, nickels};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        ev      = sync2_q & ~sync3_q;
    end

    always_comb begin
        coin_sum  = (ev[0] ? 7'd5 : 7'd0) + (ev[1] ? 7'd10 : 7'd0) + (ev[2] ? 7'd25 : 7'd0);
        coin_any  = |ev[2:0];
        sum_total = {1'b0, credit_q} + {1'b0, coin_sum};
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        gap_d         = (gap_q != '0) ? gap_q - 1'b1 : '0;
        dispance      = 1'b0;
        returnnickels = 1'b0;
        returndimes   = 1'b0;
        coin_reject   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_any) begin
                    if (sum_total <= MAX_C) credit_d = sum_total[6:0];
                    else                    coin_reject = 1'b1;
                end
                // cancel wins over vend; the coin in the same cycle is still credited
                if (ev[3] && credit_d != '0)  state_d = ST_CHANGE;
                else if (credit_d >= PRICE_C) state_d = ST_VEND;
            end
            ST_VEND: begin
                dispance    = 1'b1;
                coin_reject = coin_any;
                credit_d    = credit_q - PRICE_C;
                state_d     = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject = coin_any;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else if (gap_q == '0) begin
                    // credit is always a multiple of 5, so below 10 it is exactly 5
                    if (credit_q >= 7'd10) begin
                        returndimes = 1'b1;
                        credit_d    = credit_q - 7'd10;
                    end else begin
                        returnnickels = 1'b1;
                        credit_d      = credit_q - 7'd5;
                    end
                    gap_d = GAP_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // credit is a multiple of 5, so the ones digit is 5 exactly when credit is odd
    always_comb begin
        tens = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (credit_q >= 7'(10 * i)) tens = 4'(i);
        end
        ones = credit_q[0] ? 4'd5 : 4'd0;
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        an_d      = refresh_q[REFRESH_W-1] ? 4'b1101 : 4'b1110;
        seg_d     = seg7(refresh_q[REFRESH_W-1] ? tens : ones);
    end

    assign busy   = (state_q != ST_IDLE);
    assign credit = credit_q;
    assign an     = an_q;
    assign a_to_g = seg_q;

endmodule
